// File: rtl/pipe_ctrl_pkg.sv
// Encodings, control-bundle types and small helpers shared by the pipelined
// RV32I control unit and its ID decoder.
package pipe_ctrl_pkg;

  localparam int ALUOP_BITS = 5;
  localparam int REG_BITS   = 5;

  typedef logic [ALUOP_BITS-1:0] aluop_t;
  typedef logic [REG_BITS-1:0]   reg_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam aluop_t ALUOP_ADD  = 5'd0;
  localparam aluop_t ALUOP_SUB  = 5'd1;
  localparam aluop_t ALUOP_SLL  = 5'd2;
  localparam aluop_t ALUOP_SLT  = 5'd3;
  localparam aluop_t ALUOP_SLTU = 5'd4;
  localparam aluop_t ALUOP_XOR  = 5'd5;
  localparam aluop_t ALUOP_SRL  = 5'd6;
  localparam aluop_t ALUOP_SRA  = 5'd7;
  localparam aluop_t ALUOP_OR   = 5'd8;
  localparam aluop_t ALUOP_AND  = 5'd9;
  localparam aluop_t ALUOP_BEQ  = 5'd10;
  localparam aluop_t ALUOP_BNE  = 5'd11;
  localparam aluop_t ALUOP_BLT  = 5'd12;
  localparam aluop_t ALUOP_BGE  = 5'd13;
  localparam aluop_t ALUOP_BLTU = 5'd14;
  localparam aluop_t ALUOP_BGEU = 5'd15;
  localparam aluop_t ALUOP_NOP  = 5'd31;

  typedef struct packed {
    aluop_t     aluop;
    logic       alusrc;
    logic       branch;
    logic [1:0] jump;
    logic [1:0] asel;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    reg_t       rd;
    reg_t       rs1;
    reg_t       rs2;
  } ctrl_bundle_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
    reg_t rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    reg_t rd;
  } wb_ctrl_t;

  localparam ctrl_bundle_t BUBBLE = '{
    aluop: ALUOP_NOP, alusrc: 1'b0, branch: 1'b0, jump: 2'b00, asel: 2'b00,
    memread: 1'b0, memwrite: 1'b0, regwrite: 1'b0, memtoreg: 1'b0,
    rd: '0, rs1: '0, rs2: '0
  };
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  function automatic aluop_t alu_op(input logic [2:0] f3, input logic f7b, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && f7b) ? ALUOP_SUB : ALUOP_ADD;
      3'b001:  return ALUOP_SLL;
      3'b010:  return ALUOP_SLT;
      3'b011:  return ALUOP_SLTU;
      3'b100:  return ALUOP_XOR;
      3'b101:  return f7b ? ALUOP_SRA : ALUOP_SRL;
      3'b110:  return ALUOP_OR;
      default: return ALUOP_AND;
    endcase
  endfunction

  function automatic aluop_t br_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALUOP_BEQ;
      3'b001:  return ALUOP_BNE;
      3'b100:  return ALUOP_BLT;
      3'b101:  return ALUOP_BGE;
      3'b110:  return ALUOP_BLTU;
      3'b111:  return ALUOP_BGEU;
      default: return ALUOP_NOP;
    endcase
  endfunction

  // MEM wins over WB; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input reg_t rs, input logic mem_rw, input reg_t mem_rd,
                                         input logic wb_rw, input reg_t wb_rd);
    if (mem_rw && (mem_rd != '0) && (mem_rd == rs)) return 2'b10;
    if (wb_rw && (wb_rd != '0) && (wb_rd == rs))    return 2'b01;
    return 2'b00;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decode of an RV32I instruction into a control bundle.
// Unsupported encodings come out as a bubble with o_illegal set.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]  i_inst,
  output ctrl_bundle_t o_ctrl,
  output reg_t         o_rs1,
  output reg_t         o_rs2,
  output logic         o_rs2_used,
  output logic         o_illegal
);

  // lui/auipc produce full 32-bit upper immediates; a narrower datapath cannot hold them.
  localparam logic UPPER_IMM_OK = (XLEN >= 32);

  logic [6:0]   w_opcode;
  logic [2:0]   w_f3;
  logic         w_f7b;
  logic         w_legal;
  logic         w_rs2_used;
  ctrl_bundle_t w_ctrl;
  logic         w_unused_bits;

  assign w_opcode      = i_inst[6:0];
  assign w_f3          = i_inst[14:12];
  assign w_f7b         = i_inst[30];
  assign o_rs1         = i_inst[19:15];
  assign o_rs2         = i_inst[24:20];
  assign w_unused_bits = ^{i_inst[31], i_inst[29:25]};

  always_comb begin
    w_ctrl     = BUBBLE;
    w_ctrl.rs1 = o_rs1;
    w_ctrl.rs2 = o_rs2;
    w_legal    = 1'b1;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OP_REG: begin
        w_ctrl.aluop    = alu_op(w_f3, w_f7b, 1'b1);
        w_ctrl.regwrite = 1'b1;
        w_rs2_used      = 1'b1;
        w_legal         = !w_f7b || (w_f3 == 3'b000) || (w_f3 == 3'b101);
      end
      OP_IMM: begin
        w_ctrl.aluop    = alu_op(w_f3, w_f7b, 1'b0);
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_legal         = !((w_f3 == 3'b001) && w_f7b);
      end
      OP_LOAD: begin
        w_ctrl.aluop    = ALUOP_ADD;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memread  = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.memtoreg = 1'b1;
        w_legal         = (w_f3 == 3'b010);
      end
      OP_STORE: begin
        w_ctrl.aluop    = ALUOP_ADD;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.memwrite = 1'b1;
        w_rs2_used      = 1'b1;
        w_legal         = (w_f3 == 3'b010);
      end
      OP_BRANCH: begin
        w_ctrl.aluop  = br_op(w_f3);
        w_ctrl.branch = 1'b1;
        w_rs2_used    = 1'b1;
        w_legal       = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      OP_LUI: begin
        w_ctrl.aluop    = ALUOP_ADD;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.asel     = 2'b10;
        w_legal         = UPPER_IMM_OK;
      end
      OP_AUIPC: begin
        w_ctrl.aluop    = ALUOP_ADD;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.asel     = 2'b01;
        w_legal         = UPPER_IMM_OK;
      end
      OP_JAL: begin
        w_ctrl.aluop    = ALUOP_ADD;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.jump     = 2'b01;
        w_ctrl.asel     = 2'b01;
      end
      OP_JALR: begin
        w_ctrl.aluop    = ALUOP_ADD;
        w_ctrl.alusrc   = 1'b1;
        w_ctrl.regwrite = 1'b1;
        w_ctrl.jump     = 2'b10;
        w_legal         = (w_f3 == 3'b000);
      end
      default: w_legal = 1'b0;
    endcase
    // rd only matters for writers; keeping it 0 otherwise stops stores/branches aliasing a destination.
    w_ctrl.rd = w_ctrl.regwrite ? i_inst[11:7] : '0;
    if (!w_legal) begin
      w_ctrl     = BUBBLE;
      w_rs2_used = 1'b0;
    end
  end

  assign o_ctrl     = w_ctrl;
  assign o_rs2_used = w_rs2_used;
  assign o_illegal  = !w_legal;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined RV32I control: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, flush on taken branch/jump, and EX-stage forwarding selects.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        Inst_i,
  input  logic               InstValid_i,
  input  logic               Flush_i,
  output logic               Stall_o,
  output logic               Illegal_o,
  output logic [ALUOP_W-1:0] ex_ALUOp_o,
  output logic               ex_ALUSrc_o,
  output logic               ex_Branch_o,
  output logic [1:0]         ex_Jump_o,
  output logic [1:0]         ex_ASel_o,
  output logic [1:0]         ForwardA_o,
  output logic [1:0]         ForwardB_o,
  output logic               mem_MemRead_o,
  output logic               mem_MemWrite_o,
  output logic               wb_RegWrite_o,
  output logic               wb_MemtoReg_o,
  output logic [RA_W-1:0]    wb_rd_o
);

  ctrl_bundle_t w_dec;
  ctrl_bundle_t w_id_next;
  reg_t         w_rs1;
  reg_t         w_rs2;
  logic         w_rs2_used;
  logic         w_illegal;
  logic         w_hazard;

  ctrl_bundle_t r_ex;
  mem_ctrl_t    r_mem;
  wb_ctrl_t     r_wb;

  ctrl_decode #(.XLEN(XLEN)) u_decode (
    .i_inst     (Inst_i),
    .o_ctrl     (w_dec),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rs2_used (w_rs2_used),
    .o_illegal  (w_illegal)
  );

  assign w_hazard = r_ex.memread && (r_ex.rd != '0) && InstValid_i &&
                    ((r_ex.rd == w_rs1) || (w_rs2_used && (r_ex.rd == w_rs2)));

  assign Stall_o   = w_hazard && !Flush_i;
  assign Illegal_o = InstValid_i && w_illegal;

  // Invalid slot, load-use stall and flush all collapse to a single bubble into EX.
  assign w_id_next = (!InstValid_i || w_hazard || Flush_i) ? BUBBLE : w_dec;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex  <= BUBBLE;
      r_mem <= MEM_BUBBLE;
      r_wb  <= WB_BUBBLE;
    end else begin
      r_ex  <= w_id_next;
      r_mem <= '{memread: r_ex.memread, memwrite: r_ex.memwrite, regwrite: r_ex.regwrite,
                 memtoreg: r_ex.memtoreg, rd: r_ex.rd};
      r_wb  <= '{regwrite: r_mem.regwrite, memtoreg: r_mem.memtoreg, rd: r_mem.rd};
    end
  end

  assign ForwardA_o = fwd_sel(r_ex.rs1, r_mem.regwrite, r_mem.rd, r_wb.regwrite, r_wb.rd);
  assign ForwardB_o = fwd_sel(r_ex.rs2, r_mem.regwrite, r_mem.rd, r_wb.regwrite, r_wb.rd);

  assign ex_ALUOp_o     = ALUOP_W'(r_ex.aluop);
  assign ex_ALUSrc_o    = r_ex.alusrc;
  assign ex_Branch_o    = r_ex.branch;
  assign ex_Jump_o      = r_ex.jump;
  assign ex_ASel_o      = r_ex.asel;
  assign mem_MemRead_o  = r_mem.memread;
  assign mem_MemWrite_o = r_mem.memwrite;
  assign wb_RegWrite_o  = r_wb.regwrite;
  assign wb_MemtoReg_o  = r_wb.memtoreg;
  assign wb_rd_o        = RA_W'(r_wb.rd);

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed, table-driven bench for pipe_control_unit with hand-computed expectations,
// plus hand-written reset-during-stall and reset-with-load-in-MEM sequences.
module tb_pipe_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] Inst_i;
  logic        InstValid_i;
  logic        Flush_i;
  logic        Stall_o, Illegal_o;
  logic [4:0]  ex_ALUOp_o;
  logic        ex_ALUSrc_o, ex_Branch_o;
  logic [1:0]  ex_Jump_o, ex_ASel_o, ForwardA_o, ForwardB_o;
  logic        mem_MemRead_o, mem_MemWrite_o, wb_RegWrite_o, wb_MemtoReg_o;
  logic [4:0]  wb_rd_o;

  always #5 clk_i = ~clk_i;

  pipe_control_unit #(.XLEN(32), .RA_W(5), .ALUOP_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Inst_i(Inst_i), .InstValid_i(InstValid_i), .Flush_i(Flush_i),
    .Stall_o(Stall_o), .Illegal_o(Illegal_o), .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o),
    .ex_Branch_o(ex_Branch_o), .ex_Jump_o(ex_Jump_o), .ex_ASel_o(ex_ASel_o),
    .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o), .mem_MemRead_o(mem_MemRead_o),
    .mem_MemWrite_o(mem_MemWrite_o), .wb_RegWrite_o(wb_RegWrite_o),
    .wb_MemtoReg_o(wb_MemtoReg_o), .wb_rd_o(wb_rd_o)
  );

  localparam logic [31:0] LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] SUB7  = 32'h406303B3; // sub  x7,x6,x6
  localparam logic [31:0] BEQ   = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] LUI   = 32'h12345537; // lui  x10,0x12345
  localparam logic [31:0] AUIPC = 32'h00000597; // auipc x11,0
  localparam logic [31:0] JAL   = 32'h008000EF; // jal  x1,8
  localparam logic [31:0] JALR  = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] SW    = 32'h0050A223; // sw   x5,4(x1)
  localparam logic [31:0] SRAI  = 32'h40225193; // srai x3,x4,2
  localparam logic [31:0] ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADDX0 = 32'h00000333; // add  x6,x0,x0

  typedef struct {
    logic [31:0] inst;
    logic        valid, flush;
    logic        stall, ill;
    logic [1:0]  fa, fb;
    logic [4:0]  aluop;
    logic        alusrc, br;
    logic [1:0]  jump, asel;
    logic        mrd, mwr, rw, m2r;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   row = -1;

  function automatic vec_t mk(input logic [31:0] inst, input int valid, input int flush,
                              input int stall, input int ill, input int fa, input int fb,
                              input int aluop, input int alusrc, input int br, input int jump,
                              input int asel, input int mrd, input int mwr, input int rw,
                              input int m2r, input int rd);
    vec_t v;
    v.inst = inst;            v.valid = 1'(valid);   v.flush = 1'(flush);
    v.stall = 1'(stall);      v.ill = 1'(ill);
    v.fa = 2'(fa);            v.fb = 2'(fb);
    v.aluop = 5'(aluop);      v.alusrc = 1'(alusrc); v.br = 1'(br);
    v.jump = 2'(jump);        v.asel = 2'(asel);
    v.mrd = 1'(mrd);          v.mwr = 1'(mwr);       v.rw = 1'(rw);
    v.m2r = 1'(m2r);          v.rd = 5'(rd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): actual %0h required %0h", name, row, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] inst, input logic v, input logic f);
    rst_i = r; Inst_i = inst; InstValid_i = v; Flush_i = f;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //            inst  v fl  st il fa fb  alu src br jmp asel  mrd mwr rw m2r rd
    vecs.push_back(mk(LW5,   1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(ADD6,  1, 0,  1, 0, 0, 0, 31, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(ADD6,  1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 5));
    vecs.push_back(mk(SUB7,  1, 0,  0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(BEQ,   1, 0,  0, 0, 2, 2, 10, 0, 1, 0, 0,  0, 0, 1, 0, 6));
    vecs.push_back(mk(LUI,   1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 2,  0, 0, 1, 0, 7));
    vecs.push_back(mk(AUIPC, 1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(JAL,   1, 0,  0, 0, 0, 0,  0, 1, 0, 1, 1,  0, 0, 1, 0, 10));
    vecs.push_back(mk(JALR,  1, 0,  0, 0, 0, 0,  0, 1, 0, 2, 0,  0, 0, 1, 0, 11));
    vecs.push_back(mk(SW,    1, 0,  0, 0, 2, 0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 1));
    vecs.push_back(mk(SRAI,  1, 0,  0, 0, 1, 0,  7, 1, 0, 0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(ILL,   1, 0,  0, 1, 0, 0, 31, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(LW5,   1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 3));
    vecs.push_back(mk(ADD6,  1, 1,  0, 0, 0, 0, 31, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(LW0,   1, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 1, 1, 5));
    vecs.push_back(mk(ADDX0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(ADDX0, 0, 0,  0, 0, 0, 0, 31, 0, 0, 0, 0,  0, 0, 1, 1, 0));
    vecs.push_back(mk(ILL,   0, 0,  0, 0, 0, 0, 31, 0, 0, 0, 0,  0, 0, 1, 0, 6));
    vecs.push_back(mk(ADD6,  1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(ADD6,  1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(SUB7,  1, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0, 6));
    vecs.push_back(mk(ADDX0, 0, 0,  0, 0, 2, 2, 31, 0, 0, 0, 0,  0, 0, 1, 0, 6));

    // Reset with a valid load on the ID input: everything must come up as a bubble.
    rst_i = 1'b1; Inst_i = LW5; InstValid_i = 1'b1; Flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_aluop",  32'(ex_ALUOp_o), 32'd31);
    chk("rst_alusrc", 32'(ex_ALUSrc_o), 32'd0);
    chk("rst_branch", 32'(ex_Branch_o), 32'd0);
    chk("rst_jump",   32'(ex_Jump_o), 32'd0);
    chk("rst_asel",   32'(ex_ASel_o), 32'd0);
    chk("rst_memrd",  32'(mem_MemRead_o), 32'd0);
    chk("rst_memwr",  32'(mem_MemWrite_o), 32'd0);
    chk("rst_regwr",  32'(wb_RegWrite_o), 32'd0);
    chk("rst_m2r",    32'(wb_MemtoReg_o), 32'd0);
    chk("rst_rd",     32'(wb_rd_o), 32'd0);
    chk("rst_stall",  32'(Stall_o), 32'd0);
    chk("rst_fa",     32'(ForwardA_o), 32'd0);
    chk("rst_fb",     32'(ForwardB_o), 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      Inst_i = vecs[i].inst; InstValid_i = vecs[i].valid; Flush_i = vecs[i].flush;
      #1;
      chk("stall",   32'(Stall_o), 32'(vecs[i].stall));
      chk("illegal", 32'(Illegal_o), 32'(vecs[i].ill));
      chk("fwd_a",   32'(ForwardA_o), 32'(vecs[i].fa));
      chk("fwd_b",   32'(ForwardB_o), 32'(vecs[i].fb));
      @(posedge clk_i);
      #1;
      chk("ex_aluop",  32'(ex_ALUOp_o), 32'(vecs[i].aluop));
      chk("ex_alusrc", 32'(ex_ALUSrc_o), 32'(vecs[i].alusrc));
      chk("ex_branch", 32'(ex_Branch_o), 32'(vecs[i].br));
      chk("ex_jump",   32'(ex_Jump_o), 32'(vecs[i].jump));
      chk("ex_asel",   32'(ex_ASel_o), 32'(vecs[i].asel));
      chk("mem_rd",    32'(mem_MemRead_o), 32'(vecs[i].mrd));
      chk("mem_wr",    32'(mem_MemWrite_o), 32'(vecs[i].mwr));
      chk("wb_regwr",  32'(wb_RegWrite_o), 32'(vecs[i].rw));
      chk("wb_m2r",    32'(wb_MemtoReg_o), 32'(vecs[i].m2r));
      chk("wb_rd",     32'(wb_rd_o), 32'(vecs[i].rd));
    end

    // Reset while a load-use stall is active: the load must not reach MEM.
    row = 100;
    cyc(1'b0, LW5, 1'b1, 1'b0);
    rst_i = 1'b1; Inst_i = ADD6; InstValid_i = 1'b1; Flush_i = 1'b0;
    #1;
    chk("stall_at_rst", 32'(Stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    chk("rst_stall_memrd", 32'(mem_MemRead_o), 32'd0);
    chk("rst_stall_aluop", 32'(ex_ALUOp_o), 32'd31);
    chk("rst_stall_regwr", 32'(wb_RegWrite_o), 32'd0);

    // Reset (with flush) while the load sits in MEM.
    row = 101;
    cyc(1'b0, LW5, 1'b1, 1'b0);
    cyc(1'b0, ADD6, 1'b1, 1'b0);
    chk("lw_in_mem", 32'(mem_MemRead_o), 32'd1);
    cyc(1'b1, ADD6, 1'b1, 1'b1);
    chk("midrst_memrd", 32'(mem_MemRead_o), 32'd0);
    chk("midrst_regwr", 32'(wb_RegWrite_o), 32'd0);
    chk("midrst_rd",    32'(wb_rd_o), 32'd0);
    chk("midrst_aluop", 32'(ex_ALUOp_o), 32'd31);
    cyc(1'b0, ADD6, 1'b0, 1'b0);
    chk("postrst_regwr", 32'(wb_RegWrite_o), 32'd0);
    chk("postrst_m2r",   32'(wb_MemtoReg_o), 32'd0);
    chk("postrst_memrd", 32'(mem_MemRead_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined, parametrised control unit for the segmented RV32I core. Decodes the instruction in ID, carries the resulting control bundle through the ID/EX, EX/MEM and MEM/WB registers, and adds three things the single-cycle decoder lacked:
- load-use hazard stall,
- EX-stage forwarding selects,
- flush on a taken branch or jump.

It also extends decode to `lui`, `auipc`, `jal` and `jalr`. ALUOp decode is pure logic; no hex ROM files are used.

## Interface
Parameters:
- `XLEN`, 32, datapath width; used only for immediate-type sizing checks.
- `RA_W`, 5, register-address width.
- `ALUOP_W`, 5, ALUOp width; encodings are in the package.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `Inst_i`  in  32  instruction currently in ID.
- `InstValid_i`  in  1  `Inst_i` is valid; when 0, ID is treated as a bubble.
- `Flush_i`  in  1  branch or jump taken, resolved in EX.
- `Stall_o`  out  1  hold PC and IF/ID (combinational).
- `Illegal_o`  out  1  unsupported opcode in ID (combinational).
- `ex_ALUOp_o`  out  `ALUOP_W`  ALU operation for EX.
- `ex_ALUSrc_o`  out  1  operand B comes from the immediate.
- `ex_Branch_o`  out  1  conditional branch in EX.
- `ex_Jump_o`  out  2  00 none, 01 `jal`, 10 `jalr`.
- `ex_ASel_o`  out  2  operand A source: 00 rs1, 01 PC (`auipc`/`jal`), 10 zero (`lui`).
- `ForwardA_o`, `ForwardB_o`  out  2  00 register file, 10 from MEM, 01 from WB.
- `mem_MemRead_o`, `mem_MemWrite_o`  out  1  data-memory control in MEM.
- `wb_RegWrite_o`, `wb_MemtoReg_o`  out  1  write-back control.
- `wb_rd_o`  out  `RA_W`  write-back destination register.

## Operation
- **ID decode** on `{opcode, funct3, funct7[5]}`.
  - Supported: all RV32I branches, `lw`, `sw`, I-ALU ops, R-ALU ops, `lui`, `auipc`, `jal`, `jalr`.
  - `rs2` counts as "used" only for R-type, store and branch instructions.
- **ALUOp** for each class:
  - Loads, stores, `auipc`, `jal`, `jalr` and `lui` use ADD.
  - `lui` uses ADD with A = zero.
  - Branches map to the compare encodings.
  - Jumps set `RegWrite`; the link value is selected downstream by `ex_Jump_o`.
- **Illegal instruction.** An unrecognised opcode asserts `Illegal_o` (when `InstValid_i` = 1) and is injected as a bubble (all control bits 0, ALUOp = `ALUOP_NOP`).
- **Bubble.** A bubble has all write and enable bits 0, `rd` = 0 and ALUOp = `ALUOP_NOP`.
- **Load-use hazard.** Condition: `ex_MemRead` & (`ex_rd` ≠ 0) & (`ex_rd` == ID `rs1` | (`rs2` used & `ex_rd` == ID `rs2`)) & `InstValid_i`.
- **Stall.** `Stall_o` = hazard & ~`Flush_i`. While `Stall_o` = 1, ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- **Flush.** `Flush_i` = 1 loads a bubble into ID/EX. The branch already in EX advances into MEM.
- **Forwarding** is computed from the registered EX `rs1`/`rs2`:
  - MEM match: `mem_RegWrite` & `mem_rd` ≠ 0 & `mem_rd` == `rs` → 10.
  - Otherwise WB match, same rule with WB fields → 01.
  - Otherwise → 00.
  - MEM takes priority over WB.
- **x0.** Never forwarded and never the cause of a stall.

## Timing
- Decode to EX outputs: 1 cycle. MEM outputs: 2 cycles. WB outputs: 3 cycles.
- `Stall_o`, `Illegal_o` and the forward selects are combinational in the same cycle as their inputs.
- **Reset.** `rst_i` at a rising edge clears all three stage registers to bubble. After reset:
  - all registered outputs are 0;
  - ALUOp = `ALUOP_NOP`;
  - `Stall_o` and the forward selects are 0, because the EX bubble has `rd` = 0.
- **Reset mid-stream.** Reset asserted during a stall or flush overrides both; the pipeline restarts empty on the next cycle.
- **Flush and hazard in the same cycle.** Flush wins: `Stall_o` = 0 and a single bubble is inserted.
- **Repeated stall.** A load-use stall lasts exactly one cycle. After the bubble, the load has moved to MEM and the hazard condition is false.
- **Simultaneous MEM and WB match.** MEM is selected.

## Structure
- Package `pipe_ctrl_pkg` contains:
  - opcode constants;
  - ALUOp encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15, NOP 31;
  - the `ctrl_bundle_t` struct;
  - the `BUBBLE` constant.
- Sub-module `ctrl_decode` holds the pure combinational ID decode. The top level holds the stage registers, the hazard logic and the forwarding logic.

## Test plan
- **Load-use stall.** Sequence: `lw x5,0(x1)` (0x0000A283), then `add x6,x5,x2` (0x00228333). Required:
  - `Stall_o` = 1 for exactly one cycle;
  - the following cycle `ex_ALUOp_o` = NOP;
  - the `add` reaches EX one cycle later with `ForwardA_o` = 01.
- **MEM forwarding.** Sequence: `add x6,x5,x2`, then `sub x7,x6,x6` (0x406303B3). Required: with `sub` in EX, `ForwardA_o` = `ForwardB_o` = 10 and `ex_ALUOp_o` = 1.
- **Illegal opcode.** Input 0xFFFFFFFF with `InstValid_i` = 1. Required: `Illegal_o` = 1, and the EX bundle is a bubble next cycle.
- **Flush overrides stall.** `Flush_i` = 1 in the same cycle as a load-use hazard. Required: `Stall_o` = 0, and ID/EX is a bubble next cycle.
- **Reset mid-stream.** Assert `rst_i` while `lw` is in MEM. Required: after the edge, `mem_MemRead_o` = 0, `wb_RegWrite_o` = 0 and `wb_rd_o` = 0.
- **x0 destination.** `lw x0,0(x1)`, then `add x6,x0,x0`. Required: no stall, and forward selects = 00.
